// File: rtl/dp_cmpsel_shift_pipe.sv
`default_nettype none
// ============================================================================
// Module   : dp_cmpsel_shift_pipe
// Brief    : 3-stage add/compare/select/shift datapath with valid/ready flow
//            control. d=a+b, e=a+c, f=a-b; selects g/h from the d<e / d==e
//            compare, shifts them by the gated amounts, then truncates or
//            saturates to OUT_WIDTH.
// Revision : 1.0 - initial release
// ============================================================================
module dp_cmpsel_shift_pipe #(
  parameter int WIDTH     = 64,
  parameter int OUT_WIDTH = 32,
  parameter int SAT       = 0,
  parameter int SHW       = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [WIDTH-1:0]     c,
  input  logic [SHW-1:0]       shl_amt,
  input  logic [SHW-1:0]       shr_amt,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] x,
  output logic [OUT_WIDTH-1:0] z,
  output logic                 flag_lt,
  output logic                 flag_eq,
  output logic                 x_sat,
  output logic                 z_sat
);

  localparam bit                   c_SAT_EN  = (SAT != 0);
  localparam logic [OUT_WIDTH-1:0] c_OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] c_OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  // Flow control: a stalled output freezes the whole pipe, bubbles included.
  logic w_stall;
  logic w_adv;
  assign w_stall  = out_valid && !out_ready;
  assign w_adv    = !w_stall;
  assign in_ready = w_adv;

  // ---------------------------------------------------------------- stage 1
  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_g_q, s1_g_d;
  logic [WIDTH-1:0] s1_h_q, s1_h_d;
  logic             s1_lt_q, s1_lt_d;
  logic             s1_eq_q, s1_eq_d;
  logic [SHW-1:0]   s1_shl_q, s1_shl_d;
  logic [SHW-1:0]   s1_shr_q, s1_shr_d;

  logic [WIDTH-1:0] w_d, w_e, w_f;

  // Sums, compare, operand select and flag-gated shift amounts.
  always_comb begin
    w_d      = a + b;
    w_e      = a + c;
    w_f      = a - b;
    s1_lt_d  = $signed(w_d) < $signed(w_e);
    s1_eq_d  = (w_d == w_e);
    s1_g_d   = s1_lt_d ? w_e : w_d;
    s1_h_d   = s1_eq_d ? w_f : s1_g_d;
    s1_shl_d = s1_lt_d ? shl_amt : '0;
    s1_shr_d = s1_eq_d ? shr_amt : '0;
  end

  // Stage 1 register; payload only loads with a real beat so idle data is quiet.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_g_q     <= '0;
      s1_h_q     <= '0;
      s1_lt_q    <= 1'b0;
      s1_eq_q    <= 1'b0;
      s1_shl_q   <= '0;
      s1_shr_q   <= '0;
    end else if (w_adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_g_q   <= s1_g_d;
        s1_h_q   <= s1_h_d;
        s1_lt_q  <= s1_lt_d;
        s1_eq_q  <= s1_eq_d;
        s1_shl_q <= s1_shl_d;
        s1_shr_q <= s1_shr_d;
      end
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic             s2_valid_q;
  logic [WIDTH-1:0] s2_xr_q, s2_xr_d;
  logic [WIDTH-1:0] s2_zr_q, s2_zr_d;
  logic             s2_lt_q;
  logic             s2_eq_q;

  // Shifters: zero-amount when the gating flag was clear.
  always_comb begin
    s2_xr_d = s1_h_q << s1_shl_q;
    s2_zr_d = $signed(s1_g_q) >>> s1_shr_q;
  end

  // Stage 2 register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_xr_q    <= '0;
      s2_zr_q    <= '0;
      s2_lt_q    <= 1'b0;
      s2_eq_q    <= 1'b0;
    end else if (w_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_xr_q <= s2_xr_d;
        s2_zr_q <= s2_zr_d;
        s2_lt_q <= s1_lt_q;
        s2_eq_q <= s1_eq_q;
      end
    end
  end

  // ---------------------------------------------------------------- stage 3
  logic                 s3_valid_q;
  logic [OUT_WIDTH-1:0] s3_x_q, s3_x_d;
  logic [OUT_WIDTH-1:0] s3_z_q, s3_z_d;
  logic                 s3_lt_q;
  logic                 s3_eq_q;
  logic                 s3_xs_q, s3_xs_d;
  logic                 s3_zs_q, s3_zs_d;

  // A value fits OUT_WIDTH iff all bits from OUT_WIDTH-1 upward equal the sign.
  logic [WIDTH-OUT_WIDTH:0] w_x_top, w_z_top;
  logic                     w_x_ovf, w_z_ovf;

  // Resize: truncate, or clamp toward the sign when saturation is enabled.
  always_comb begin
    w_x_top = s2_xr_q[WIDTH-1:OUT_WIDTH-1];
    w_z_top = s2_zr_q[WIDTH-1:OUT_WIDTH-1];
    w_x_ovf = !((&w_x_top) || !(|w_x_top));
    w_z_ovf = !((&w_z_top) || !(|w_z_top));
    s3_x_d  = s2_xr_q[OUT_WIDTH-1:0];
    s3_z_d  = s2_zr_q[OUT_WIDTH-1:0];
    s3_xs_d = 1'b0;
    s3_zs_d = 1'b0;
    if (c_SAT_EN && w_x_ovf) begin
      s3_x_d  = s2_xr_q[WIDTH-1] ? c_OUT_MIN : c_OUT_MAX;
      s3_xs_d = 1'b1;
    end
    if (c_SAT_EN && w_z_ovf) begin
      s3_z_d  = s2_zr_q[WIDTH-1] ? c_OUT_MIN : c_OUT_MAX;
      s3_zs_d = 1'b1;
    end
  end

  // Output register; holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s3_valid_q <= 1'b0;
      s3_x_q     <= '0;
      s3_z_q     <= '0;
      s3_lt_q    <= 1'b0;
      s3_eq_q    <= 1'b0;
      s3_xs_q    <= 1'b0;
      s3_zs_q    <= 1'b0;
    end else if (w_adv) begin
      s3_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        s3_x_q  <= s3_x_d;
        s3_z_q  <= s3_z_d;
        s3_lt_q <= s2_lt_q;
        s3_eq_q <= s2_eq_q;
        s3_xs_q <= s3_xs_d;
        s3_zs_q <= s3_zs_d;
      end
    end
  end

  assign out_valid = s3_valid_q;
  assign x         = s3_x_q;
  assign z         = s3_z_q;
  assign flag_lt   = s3_lt_q;
  assign flag_eq   = s3_eq_q;
  assign x_sat     = s3_xs_q;
  assign z_sat     = s3_zs_q;

endmodule
`default_nettype wire

// File: tb/tb_dp_cmpsel_shift_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_dp_cmpsel_shift_pipe
// Brief    : Self-checking bench for dp_cmpsel_shift_pipe. A truncating and a
//            saturating instance share stimulus; a reference model feeds a
//            scoreboard queue that is drained as results are consumed.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dp_cmpsel_shift_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [63:0] a, b, c;
  logic [5:0]  shl_amt, shr_amt;

  logic        ir0, ov0, lt0, eq0, xs0, zs0;
  logic [31:0] x0, z0;
  logic        ir1, ov1, lt1, eq1, xs1, zs1;
  logic [31:0] x1, z1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] x0, z0;
    logic        lt, eq;
    logic [31:0] x1, z1;
    logic        xs1, zs1;
  } exp_t;

  exp_t q[$];

  logic        held = 1'b0;
  logic [31:0] hx0, hz0, hx1, hz1;
  logic        hlt, heq;

  always #5 clk = ~clk;

  dp_cmpsel_shift_pipe #(.WIDTH(64), .OUT_WIDTH(32), .SAT(0)) u_trunc (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0),
    .a(a), .b(b), .c(c), .shl_amt(shl_amt), .shr_amt(shr_amt),
    .out_valid(ov0), .out_ready(out_ready), .x(x0), .z(z0),
    .flag_lt(lt0), .flag_eq(eq0), .x_sat(xs0), .z_sat(zs0)
  );

  dp_cmpsel_shift_pipe #(.WIDTH(64), .OUT_WIDTH(32), .SAT(1)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1),
    .a(a), .b(b), .c(c), .shl_amt(shl_amt), .shr_amt(shr_amt),
    .out_valid(ov1), .out_ready(out_ready), .x(x1), .z(z1),
    .flag_lt(lt1), .flag_eq(eq1), .x_sat(xs1), .z_sat(zs1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model at 64-bit signed arithmetic.
  function automatic exp_t model(input longint ma, input longint mb, input longint mc,
                                 input int shl, input int shr);
    exp_t   r;
    longint d, e, f, g, h, xr, zr, xs, zs;
    longint maxv = 64'sd2147483647;
    longint minv = -64'sd2147483648;
    d = ma + mb;
    e = ma + mc;
    f = ma - mb;
    r.lt = (d < e);
    r.eq = (d == e);
    g  = r.lt ? e : d;
    h  = r.eq ? f : g;
    xr = r.lt ? (h << shl) : h;
    zr = r.eq ? (g >>> shr) : g;
    r.x0 = xr[31:0];
    r.z0 = zr[31:0];
    r.xs1 = 1'b0;
    r.zs1 = 1'b0;
    xs = xr;
    zs = zr;
    if (xr > maxv) begin xs = maxv; r.xs1 = 1'b1; end
    else if (xr < minv) begin xs = minv; r.xs1 = 1'b1; end
    if (zr > maxv) begin zs = maxv; r.zs1 = 1'b1; end
    else if (zr < minv) begin zs = minv; r.zs1 = 1'b1; end
    r.x1 = xs[31:0];
    r.z1 = zs[31:0];
    return r;
  endfunction

  task automatic monitor_step();
    exp_t e;
    if (rst) begin
      q.delete();
      held = 1'b0;
      return;
    end
    if (held) begin
      chk("hold_x0", x0, hx0);
      chk("hold_z0", z0, hz0);
      chk("hold_x1", x1, hx1);
      chk("hold_z1", z1, hz1);
      chk("hold_flags", {lt0, eq0}, {hlt, heq});
    end
    held = ov0 && !out_ready;
    hx0 = x0; hz0 = z0; hx1 = x1; hz1 = z1; hlt = lt0; heq = eq0;
    if (ov0 && out_ready) begin
      chk("ov_match", ov1, 1'b1);
      if (q.size() == 0) begin
        chk("unexpected_out", 1'b1, 1'b0);
      end else begin
        e = q.pop_front();
        chk("x_trunc", x0, e.x0);
        chk("z_trunc", z0, e.z0);
        chk("flags_trunc", {lt0, eq0, xs0, zs0}, {e.lt, e.eq, 2'b00});
        chk("x_sat", x1, e.x1);
        chk("z_sat", z1, e.z1);
        chk("flags_sat", {lt1, eq1, xs1, zs1}, {e.lt, e.eq, e.xs1, e.zs1});
      end
    end
    if (in_valid && ir0)
      q.push_back(model($signed(a), $signed(b), $signed(c), int'(shl_amt), int'(shr_amt)));
  endtask

  // Scoreboard: sample away from the rising edge.
  always @(negedge clk) monitor_step();

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_beat(input int i);
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    c = (i % 3 == 0) ? b : {$urandom, $urandom};
    if (i % 2 == 1) begin
      a = 64'($signed(a[31:0]));
      b = 64'($signed(b[15:0]));
    end
    shl_amt = 6'($urandom_range(0, 63));
    shr_amt = 6'($urandom_range(0, 63));
  endtask

  // One beat into an empty pipe; result must appear exactly 3 cycles later.
  task automatic send_lat(input logic [63:0] ta, input logic [63:0] tb, input logic [63:0] tc,
                          input logic [5:0] tl, input logic [5:0] tr,
                          input logic [31:0] ex0, input logic [31:0] ez0,
                          input logic elt, input logic eeq,
                          input logic [31:0] ex1, input logic [31:0] ez1,
                          input logic exs, input logic ezs);
    in_valid = 1'b1;
    a = ta; b = tb; c = tc; shl_amt = tl; shr_amt = tr;
    @(negedge clk);
    chk("lat_c0_ov", ov0, 1'b0);
    chk("lat_c0_ready", ir0, 1'b1);
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_c1_ov", ov0, 1'b0);
    next_cycle();
    @(negedge clk);
    chk("lat_c2_ov", ov0, 1'b0);
    next_cycle();
    @(negedge clk);
    chk("lat_c3_ov", {ov0, ov1}, 2'b11);
    chk("dir_x0", x0, ex0);
    chk("dir_z0", z0, ez0);
    chk("dir_flags0", {lt0, eq0, xs0, zs0}, {elt, eeq, 2'b00});
    chk("dir_x1", x1, ex1);
    chk("dir_z1", z1, ez1);
    chk("dir_flags1", {lt1, eq1, xs1, zs1}, {elt, eeq, exs, ezs});
    next_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    logic pat;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; c = '0; shl_amt = '0; shr_amt = '0;
    repeat (3) next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ov", {ov0, ov1}, 2'b00);
    chk("rst_ready", {ir0, ir1}, 2'b11);
    chk("rst_xz", {x0, z0, x1, z1}, 128'd0);
    chk("rst_flags", {lt0, eq0, xs0, zs0, lt1, eq1, xs1, zs1}, 8'd0);
    next_cycle();

    // Directed beats.
    send_lat(64'd10, 64'd3, 64'd5, 6'd1, 6'd1,
             32'd30, 32'd15, 1'b1, 1'b0, 32'd30, 32'd15, 1'b0, 1'b0);
    send_lat(64'd4, 64'd2, 64'd2, 6'd0, 6'd1,
             32'd2, 32'd3, 1'b0, 1'b1, 32'd2, 32'd3, 1'b0, 1'b0);
    send_lat(-64'sd20, -64'sd4, -64'sd4, 6'd0, 6'd2,
             32'hFFFF_FFF0, 32'hFFFF_FFFA, 1'b0, 1'b1,
             32'hFFFF_FFF0, 32'hFFFF_FFFA, 1'b0, 1'b0);
    send_lat(64'h4000_0000, 64'h4000_0000, 64'd0, 6'd0, 6'd0,
             32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0,
             32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b1);

    // Backpressure: 8 back-to-back beats, consumer stalls 5 cycles.
    sent = 0;
    for (int k = 0; k < 40 && sent < 8; k++) begin
      out_ready = !(k >= 4 && k < 9);
      in_valid  = 1'b1;
      rand_beat(sent);
      @(negedge clk);
      if (k >= 4 && k < 9) chk("stall_ready", {ir0, ir1}, 2'b00);
      if (ir0) sent++;
      next_cycle();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp_all_sent", sent, 8);
    repeat (6) next_cycle();
    chk("bp_drained", q.size(), 0);

    // Bubbles: alternating in_valid, out_valid follows 3 cycles later.
    for (int k = 0; k < 12; k++) begin
      in_valid = (k < 8) && (k % 2 == 0);
      rand_beat(k);
      @(negedge clk);
      pat = (k >= 3) && (k - 3 < 8) && ((k - 3) % 2 == 0);
      chk("bubble_ov", ov0, pat);
      next_cycle();
    end
    in_valid = 1'b0;

    // Reset with 3 beats in flight.
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      rand_beat(k);
      next_cycle();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_ov", {ov0, ov1}, 2'b00);
    chk("mrst_xz", {x0, z0, x1, z1}, 128'd0);
    chk("mrst_flags", {lt0, eq0, xs0, zs0, lt1, eq1, xs1, zs1}, 8'd0);
    next_cycle();
    send_lat(64'd10, 64'd3, 64'd5, 6'd1, 6'd1,
             32'd30, 32'd15, 1'b1, 1'b0, 32'd30, 32'd15, 1'b0, 1'b0);

    repeat (4) next_cycle();
    chk("final_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
